// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: frame-level controller behind the UART byte receiver.
//
// Takes the receiver's one-cycle byte strobes and hunts for SYNC_BYTE. It then
// parses a frame of the form SYNC, LEN, LEN payload bytes, CSUM into a local
// buffer, where CSUM = (LEN + sum of payload) mod 256. When the checksum
// matches, the payload drains to the consumer over a valid/ready stream.
//
// Optional feature (compile-time macro RX_FRAME_TIMEOUT_EN):
//   defined     - an idle counter aborts a frame that stalls for TIMEOUT_CLKS
//                 clocks between bytes, reporting err_code=3.
//   not defined - no counter; a stalled frame waits indefinitely.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   [7:0] received byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe per received byte
//   out_data   out  [7:0] payload byte (0 when not draining)
//   out_valid  out  payload byte available
//   out_last   out  final payload byte of the frame
//   out_ready  in   consumer accepts byte when high with out_valid
//   frame_err  out  one-cycle error pulse
//   err_code   out  [1:0] 1=bad length, 2=bad checksum, 3=timeout; held until next error
//   drop_cnt   out  [7:0] bytes dropped while draining, saturating at 255
module rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] drop_cnt
);

    localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

    localparam logic [1:0] ErrLen  = 2'd1;
    localparam logic [1:0] ErrCsum = 2'd2;
`ifdef RX_FRAME_TIMEOUT_EN
    localparam logic [1:0] ErrTmo  = 2'd3;
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CLKS + 1);
`endif

    // Elaboration-time guard on the parameter ranges the datapath relies on.
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_params
        $error("rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 2");
    end

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPayload,
        StCsum,
        StDrain
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] wr_idx_q, wr_idx_d;
    logic [7:0] rd_idx_q, rd_idx_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       buf_we;
    logic [7:0] buf_q [MAX_LEN];

`ifdef RX_FRAME_TIMEOUT_EN
    logic [TmoW-1:0] idle_q, idle_d;
`endif

    logic [IdxW-1:0] wr_ptr;
    logic [IdxW-1:0] rd_ptr;
    logic            draining;
    logic            last_byte;

    // Indices never exceed len-1 <= MAX_LEN-1, so the low bits address the buffer.
    assign wr_ptr    = wr_idx_q[IdxW-1:0];
    assign rd_ptr    = rd_idx_q[IdxW-1:0];
    assign draining  = (state_q == StDrain);
    assign last_byte = (rd_idx_q == (len_q - 8'd1));

    // Stream outputs come only from registers; out_ready never reaches them.
    assign out_valid = draining;
    assign out_data  = draining ? buf_q[rd_ptr] : 8'h00;
    assign out_last  = draining && last_byte;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        drop_cnt_d  = drop_cnt_q;
        buf_we      = 1'b0;
`ifdef RX_FRAME_TIMEOUT_EN
        idle_d      = '0;
`endif

        unique case (state_q)
            StHunt: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = StLen;
                end
            end

            StLen: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (rx_data > MaxLenB)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ErrLen;
                        state_d     = StHunt;
                    end else begin
                        len_d    = rx_data;
                        sum_d    = rx_data;
                        wr_idx_d = 8'd0;
                        state_d  = StPayload;
                    end
                end
            end

            StPayload: begin
                if (rx_valid) begin
                    buf_we   = 1'b1;
                    sum_d    = sum_q + rx_data;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if (wr_idx_q == (len_q - 8'd1)) begin
                        state_d = StCsum;
                    end
                end
            end

            StCsum: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        rd_idx_d = 8'd0;
                        state_d  = StDrain;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ErrCsum;
                        state_d     = StHunt;
                    end
                end
            end

            StDrain: begin
                // Bytes arriving while draining are lost; no sync detection here.
                if (rx_valid && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + 8'd1;
                    if (last_byte) begin
                        state_d = StHunt;
                    end
                end
            end

            default: begin
                state_d = StHunt;
            end
        endcase

`ifdef RX_FRAME_TIMEOUT_EN
        // A received byte wins over expiry in the same cycle.
        if ((state_q == StLen) || (state_q == StPayload) || (state_q == StCsum)) begin
            if (rx_valid) begin
                idle_d = '0;
            end else if (idle_q == TmoW'(TIMEOUT_CLKS - 1)) begin
                frame_err_d = 1'b1;
                err_code_d  = ErrTmo;
                state_d     = StHunt;
                idle_d      = '0;
            end else begin
                idle_d = idle_q + TmoW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            wr_idx_q    <= 8'd0;
            rd_idx_q    <= 8'd0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

`ifdef RX_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // Payload storage carries no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_ptr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
module tb_rx_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;

    rx_frame_ctrl #(
        .SYNC_BYTE   (8'hA5),
        .MAX_LEN     (16),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .err_code (err_code),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    // Present one byte for one clock; returns 1 time unit after the edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", out_last); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", frame_err); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL rst_code: got %0d want 0", err_code); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        int e0;
        e0 = err_pulses;
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h63);
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h10, 1'b0}) begin n_fail++;
            $display("FAIL good_b0: got v=%b d=%h l=%b want v=1 d=10 l=0", out_valid, out_data, out_last); end
        tick();
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h20, 1'b0}) begin n_fail++;
            $display("FAIL good_b1: got v=%b d=%h l=%b want v=1 d=20 l=0", out_valid, out_data, out_last); end
        tick();
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h30, 1'b1}) begin n_fail++;
            $display("FAIL good_b2: got v=%b d=%h l=%b want v=1 d=30 l=1", out_valid, out_data, out_last); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_end: out_valid=%b want 0", out_valid); end
        n_checks++; if (err_pulses !== e0) begin n_fail++; $display("FAIL good_noerr: pulses=%0d want %0d", err_pulses, e0); end
    endtask

    task automatic test_sync_hunt();
        int e0;
        e0 = err_pulses;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A); send_byte(8'hA5);
        // CSUM = LEN + payload = 01 + 7E = 7F
        send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h7E, 1'b1}) begin n_fail++;
            $display("FAIL hunt_b0: got v=%b d=%h l=%b want v=1 d=7e l=1", out_valid, out_data, out_last); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hunt_end: out_valid=%b want 0", out_valid); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL hunt_drop: got %0d want 0", drop_cnt); end
        n_checks++; if (err_pulses !== e0) begin n_fail++; $display("FAIL hunt_noerr: pulses=%0d want %0d", err_pulses, e0); end
    endtask

    task automatic test_bad_length();
        int e0;
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h00);
        n_checks++; if ({frame_err, err_code} !== {1'b1, 2'd1}) begin n_fail++;
            $display("FAIL len0_err: got err=%b code=%0d want err=1 code=1", frame_err, err_code); end
        tick();
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL len0_pulse: frame_err=%b want 0", frame_err); end
        send_byte(8'hA5); send_byte(8'h11);
        n_checks++; if ({frame_err, err_code} !== {1'b1, 2'd1}) begin n_fail++;
            $display("FAIL len17_err: got err=%b code=%0d want err=1 code=1", frame_err, err_code); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len_novalid: out_valid=%b want 0", out_valid); end
        n_checks++; if (err_pulses !== e0 + 2) begin n_fail++; $display("FAIL len_pulses: got %0d want %0d", err_pulses, e0 + 2); end
    endtask

    task automatic test_bad_checksum();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF);
        n_checks++; if ({frame_err, err_code} !== {1'b1, 2'd2}) begin n_fail++;
            $display("FAIL csum_err: got err=%b code=%0d want err=1 code=2", frame_err, err_code); end
        tick();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09); send_byte(8'h0A);
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h09, 1'b1}) begin n_fail++;
            $display("FAIL csum_next: got v=%b d=%h l=%b want v=1 d=09 l=1", out_valid, out_data, out_last); end
        n_checks++; if (err_code !== 2'd2) begin n_fail++; $display("FAIL csum_hold: err_code=%0d want 2", err_code); end
        tick();
    endtask

    task automatic test_max_len();
        int bad;
        bad = 0;
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        // 16 + (1+..+16) = 152 = 8'h98
        send_byte(8'h98);
        for (int i = 0; i < 16; i++) begin
            if ({out_valid, out_data, out_last} !== {1'b1, 8'(i + 1), (i == 15)}) begin
                bad++;
                $display("FAIL maxlen_b%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, 8'(i + 1), (i == 15));
            end
            tick();
        end
        n_checks++; if (bad != 0) n_fail++;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL maxlen_end: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
        repeat (99) tick();
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: frame_err=%b want 0", frame_err); end
        tick();
`ifdef RX_FRAME_TIMEOUT_EN
        n_checks++; if ({frame_err, err_code} !== {1'b1, 2'd3}) begin n_fail++;
            $display("FAIL tmo_err: got err=%b code=%0d want err=1 code=3", frame_err, err_code); end
        tick();
        n_checks++; if (err_pulses !== e0 + 1) begin n_fail++; $display("FAIL tmo_pulses: got %0d want %0d", err_pulses, e0 + 1); end
`else
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_none: frame_err=%b want 0", frame_err); end
        send_byte(8'h20); send_byte(8'h30); send_byte(8'h63);
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h10}) begin n_fail++;
            $display("FAIL tmo_resume: got v=%b d=%h want v=1 d=10", out_valid, out_data); end
        repeat (3) tick();
        n_checks++; if (err_pulses !== e0) begin n_fail++; $display("FAIL tmo_pulses: got %0d want %0d", err_pulses, e0); end
`endif
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h63);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL bp_drop3: got %0d want 3", drop_cnt); end
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h10, 1'b0}) begin n_fail++;
            $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=10 l=0", out_valid, out_data, out_last); end
        repeat (297) send_byte(8'hA5);
        n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL bp_sat: got %0d want 255", drop_cnt); end
        n_checks++; if (out_data !== 8'h10) begin n_fail++; $display("FAIL bp_hold2: got %h want 10", out_data); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== 8'h20) begin n_fail++; $display("FAIL bp_b1: got %h want 20", out_data); end
        tick();
        n_checks++; if ({out_data, out_last} !== {8'h30, 1'b1}) begin n_fail++;
            $display("FAIL bp_b2: got d=%h l=%b want d=30 l=1", out_data, out_last); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, out_data, drop_cnt} !== {1'b0, 8'h00, 8'h00}) begin n_fail++;
            $display("FAIL rstmid_drain: got v=%b d=%h drop=%0d want 0/00/0", out_valid, out_data, drop_cnt); end
        @(posedge clk); #1; rst_n = 1'b1;
        // Half a frame, reset, then its tail: the tail must be ignored.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        send_byte(8'h22); send_byte(8'h35);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame: out_valid=%b want 0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h42, 1'b1}) begin n_fail++;
            $display("FAIL b2b_b0: got v=%b d=%h l=%b want v=1 d=42 l=1", out_valid, out_data, out_last); end
        // Byte in the accept cycle is dropped; the next cycle is parsed.
        send_byte(8'hA5);
        n_checks++; if ({out_valid, drop_cnt} !== {1'b0, 8'd1}) begin n_fail++;
            $display("FAIL b2b_drop: got v=%b drop=%0d want v=0 drop=1", out_valid, drop_cnt); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h56);
        n_checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h55, 1'b1}) begin n_fail++;
            $display("FAIL b2b_next: got v=%b d=%h l=%b want v=1 d=55 l=1", out_valid, out_data, out_last); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: out_valid=%b want 0", out_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_good_frame();
        test_sync_hunt();
        test_bad_length();
        test_bad_checksum();
        test_max_len();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
